// File: rtl/edge_fetcher_pkg.sv
// edge_fetcher_pkg
//   Shared definitions for the graph-adjacency edge fetcher:
//   - default BlockRam geometry and edge-count limit
//   - FSM state encodings
//   - word-stride helper (bytes per BlockRam word)
//   No ports.

package edge_fetcher_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 16;
  localparam int DEFAULT_MDATA_WIDTH = 32;
  localparam int DEFAULT_MAX_EDGES   = 64;

  typedef enum logic [2:0] {
    EF_IDLE    = 3'd0,
    EF_HDR_RD  = 3'd1,
    EF_CALC    = 3'd2,
    EF_EDGE_RD = 3'd3,
    EF_EMIT    = 3'd4,
    EF_DONE    = 3'd5
  } ef_state_t;

  // Byte stride between consecutive BlockRam words.
  function automatic int word_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/edge_fetcher_mem_read_port.sv
// mem_read_port
//   Read-request shaper for a BlockRam reader. The client raises req for as
//   long as it wants a word; mem_read_enable follows req, is held until
//   mem_read_ready, and is forced low for the cycle after every completed
//   read so back-to-back requests are always separated.
// Ports:
//   clock, reset       system clock (rising edge), synchronous active-high reset
//   req                client wants a read
//   mem_read_ready     BlockRam read-complete strobe
//   mem_read_enable    BlockRam read request
//   read_done          one-cycle strobe: read completed, data valid this cycle

module mem_read_port (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic mem_read_ready,
  output logic mem_read_enable,
  output logic read_done
);

  logic cooldown;

  assign mem_read_enable = req & ~cooldown;
  assign read_done       = mem_read_enable & mem_read_ready;

  // Remember that a read just finished so the next request waits a cycle.
  always_ff @(posedge clock) begin
    if (reset) cooldown <= 1'b0;
    else       cooldown <= read_done;
  end

endmodule

// File: rtl/edge_fetcher.sv
// edge_fetcher
//   Reads a node header from BlockRam, then walks the node's edge list one
//   word at a time and streams (neighbour, weight) pairs over valid/ready.
//   Header word: [H-1:0] edge-list byte address, [W-1:H] edge count.
//   Edge word:   [H-1:0] neighbour,              [W-1:H] weight.
//   Optional bounds checking is compiled in with EDGE_FETCH_BOUNDS_CHECK_EN;
//   without it err is tied low and addresses wrap silently.
// Ports:
//   clock, reset                  clock (rising edge), synchronous active-high reset
//   start, node_index             launch a fetch (sampled only when idle)
//   busy, done                    activity flag, one-cycle completion pulse
//   mem_read_enable/ready, mem_addr, mem_read_data   BlockRam read side
//   edge_valid/ready, edge_node, edge_weight, edge_last   edge stream
//   err                           bounds error (optional feature)

module edge_fetcher import edge_fetcher_pkg::*; #(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int NODE_BASE   = 0,
  parameter int MAX_EDGES   = DEFAULT_MAX_EDGES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MDATA_WIDTH/2-1:0] node_index,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_read_enable,
  input  logic                     mem_read_ready,
  output logic [MADDR_WIDTH-1:0]   mem_addr,
  input  logic [MDATA_WIDTH-1:0]   mem_read_data,
  output logic                     edge_valid,
  input  logic                     edge_ready,
  output logic [MDATA_WIDTH/2-1:0] edge_node,
  output logic [MDATA_WIDTH/2-1:0] edge_weight,
  output logic                     edge_last,
  output logic                     err
);

  localparam int H  = MDATA_WIDTH / 2;
  localparam int WB = word_bytes(MDATA_WIDTH);
  localparam logic [MADDR_WIDTH-1:0] WB_ADDR   = MADDR_WIDTH'(WB);
  localparam logic [MADDR_WIDTH-1:0] BASE_ADDR = MADDR_WIDTH'(NODE_BASE);
  localparam logic [H-1:0]           ONE_H     = H'(1);

  if ((MDATA_WIDTH % 8) != 0 || MAX_EDGES < 1) begin : g_param_check
    $error("edge_fetcher: MDATA_WIDTH must be a multiple of 8 and MAX_EDGES positive");
  end

  ef_state_t state, state_next;

  logic [MADDR_WIDTH-1:0] start_addr;
  logic [H-1:0]           remaining;
  logic                   read_req;
  logic                   read_done;
  logic                   bounds_bad;

  mem_read_port u_read_port (
    .clock           (clock),
    .reset           (reset),
    .req             (read_req),
    .mem_read_ready  (mem_read_ready),
    .mem_read_enable (mem_read_enable),
    .read_done       (read_done)
  );

`ifdef EDGE_FETCH_BOUNDS_CHECK_EN
  // Widened so the end-of-list address cannot itself overflow. In CALC,
  // remaining still holds the full edge count from the header.
  localparam int EXT_W = MADDR_WIDTH + H + 4;
  logic [EXT_W-1:0] span_end;
  logic             err_q;

  assign span_end   = EXT_W'(start_addr) + EXT_W'(remaining) * EXT_W'(WB);
  assign bounds_bad = (EXT_W'(remaining) > EXT_W'(MAX_EDGES)) ||
                      (span_end > (EXT_W'(1) << MADDR_WIDTH));
  assign err        = err_q;

  // err is sticky through DONE and clears only on the next accepted start.
  always_ff @(posedge clock) begin
    if (reset)                              err_q <= 1'b0;
    else if (state == EF_IDLE && start)     err_q <= 1'b0;
    else if (state == EF_CALC && bounds_bad) err_q <= 1'b1;
  end
`else
  assign bounds_bad = 1'b0;
  assign err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= EF_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; read requests are raised only in the two read states.
  always_comb begin
    state_next = state;
    read_req   = 1'b0;
    case (state)
      EF_IDLE:    if (start) state_next = EF_HDR_RD;
      EF_HDR_RD: begin
        read_req = 1'b1;
        if (read_done) state_next = EF_CALC;
      end
      EF_CALC: begin
        if (bounds_bad || remaining == '0) state_next = EF_DONE;
        else                               state_next = EF_EDGE_RD;
      end
      EF_EDGE_RD: begin
        read_req = 1'b1;
        if (read_done) state_next = EF_EMIT;
      end
      EF_EMIT: begin
        if (edge_ready) state_next = (remaining == '0) ? EF_DONE : EF_EDGE_RD;
      end
      EF_DONE:    state_next = EF_IDLE;
      default:    state_next = EF_IDLE;
    endcase
  end

  assign busy       = (state != EF_IDLE);
  assign done       = (state == EF_DONE);
  assign edge_valid = (state == EF_EMIT);

  // Datapath: address walk, remaining-edge counter and registered edge fields.
  // Edge fields are written only on a completed read, so they stay put while
  // the consumer stalls in EMIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= '0;
      start_addr  <= '0;
      remaining   <= '0;
      edge_node   <= '0;
      edge_weight <= '0;
      edge_last   <= 1'b0;
    end else begin
      case (state)
        EF_IDLE: begin
          if (start) mem_addr <= BASE_ADDR + MADDR_WIDTH'(node_index) * WB_ADDR;
        end
        EF_HDR_RD: begin
          if (read_done) begin
            start_addr <= MADDR_WIDTH'(mem_read_data[H-1:0]);
            remaining  <= mem_read_data[MDATA_WIDTH-1:H];
          end
        end
        EF_CALC: mem_addr <= start_addr;
        EF_EDGE_RD: begin
          if (read_done) begin
            edge_node   <= mem_read_data[H-1:0];
            edge_weight <= mem_read_data[MDATA_WIDTH-1:H];
            edge_last   <= (remaining == ONE_H);
            remaining   <= remaining - ONE_H;
          end
        end
        EF_EMIT: begin
          if (edge_ready && remaining != '0) mem_addr <= mem_addr + WB_ADDR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/edge_fetcher.md
Name: edge_fetcher

Overview:
- Graph-adjacency reader on the read side of BlockRam.
- Given a node index, reads that node's header word, then walks its edge list one word at a time over the BlockRam read handshake.
- Streams (neighbour, weight) pairs to the pathfinding core over a valid/ready interface.
- Sole BlockRam master while busy; mem_write_enable is not driven by this block.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: BlockRam byte-address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: BlockRam word width; must be even and a multiple of 8.
- NODE_BASE, 0: byte address of node-header table entry 0.
- MAX_EDGES, 64: edge-count limit; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch a fetch for node_index; sampled only in IDLE.
- node_index  in  MDATA_WIDTH/2  node to expand.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the fetch completes.
- mem_read_enable  out  1  BlockRam read request.
- mem_read_ready  in  1  BlockRam read-complete strobe; mem_read_data valid in the same cycle.
- mem_addr  out  MADDR_WIDTH  BlockRam byte address.
- mem_read_data  in  MDATA_WIDTH  BlockRam read data.
- edge_valid  out  1  edge output valid.
- edge_ready  in  1  consumer accepts the edge.
- edge_node  out  MDATA_WIDTH/2  neighbour index.
- edge_weight  out  MDATA_WIDTH/2  edge weight.
- edge_last  out  1  marks the final edge of the node.
- err  out  1  bounds error; only with the optional feature, otherwise tied 0.

Behaviour:
- Constants: H = MDATA_WIDTH/2; WB = MDATA_WIDTH/8 (word stride in bytes).
- Header word: [H-1:0] = edge-list start byte address, truncated to MADDR_WIDTH; [MDATA_WIDTH-1:H] = edge count.
- Edge word: [H-1:0] = neighbour; [MDATA_WIDTH-1:H] = weight.
- All address arithmetic is modulo 2^MADDR_WIDTH; wrap-around is silent.
- Reset: state=IDLE. busy, done, mem_read_enable, edge_valid, edge_last, err all 0; mem_addr=0; edge_node=0; edge_weight=0.
- Reset mid-fetch: abandon the fetch. mem_read_enable is low from the first edge after reset; no done pulse.
- IDLE:
  - If start: mem_addr <= NODE_BASE + node_index*WB, then go to HDR_RD.
  - start in any other state is ignored.
- HDR_RD:
  - mem_read_enable=1, held until mem_read_ready=1.
  - In the ready cycle, latch start address into an address register and count into a remaining counter; go to CALC.
- CALC (1 cycle):
  - mem_read_enable=0; mem_addr <= start address.
  - If count==0, go to DONE. Else go to EDGE_RD.
- EDGE_RD:
  - mem_read_enable=1 until mem_read_ready.
  - In the ready cycle, register the edge output fields, set edge_last=(remaining==1), decrement remaining, go to EMIT.
- EMIT:
  - mem_read_enable=0; edge_valid=1.
  - edge_node, edge_weight and edge_last stay stable while edge_ready=0.
  - On edge_ready:
    - edge_valid drops next cycle.
    - If remaining==0, go to DONE.
    - Else mem_addr <= mem_addr+WB and go to EDGE_RD.
- DONE:
  - done=1 for exactly one cycle, then IDLE; busy falls with the return to IDLE.
  - start in this cycle is ignored.
- Read-request spacing: mem_read_enable is low for at least one cycle between consecutive requests.
- Latency, count=N, zero-wait consumer, BlockRam read latency L: done arrives (L+1)+1+N*(L+2)+1 cycles after start is accepted.

Optional Feature:
- Macro: EDGE_FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In CALC, if count > MAX_EDGES, or start+count*WB overflows 2^MADDR_WIDTH, set err=1.
  - The block then emits no edges and goes to DONE.
  - err stays high until the next accepted start or reset.
- Undefined: no checks; err tied 0; addresses wrap silently.

Decomposition:
- Additions to constants.v:
  - State encodings EF_IDLE, EF_HDR_RD, EF_CALC, EF_EDGE_RD, EF_EMIT, EF_DONE.
  - Default MAX_EDGES.
- Sub-module mem_read_port:
  - Holds mem_read_enable until mem_read_ready.
  - Drops it for at least one cycle after each completed read.
  - Reusable by other BlockRam readers.

Test Plan:
- Bench setup: MADDR_WIDTH=16, MDATA_WIDTH=32, NODE_BASE=0; memory is preloaded through BlockRam's write port before handoff.
- Node 2, header 0x0003_0040; edges at 0x40/0x44/0x48 = 0x0005_0001, 0x0007_0002, 0x0009_0003:
  - Three handshakes: (node 1, weight 5), (node 2, weight 7), (node 3, weight 9).
  - edge_last only on the third.
  - One done pulse; busy low afterwards.
- Same node, edge_ready held low 5 cycles per edge: outputs stable while stalled; no extra memory reads; same sequence.
- Header 0x0000_0080: no edge_valid; done 1 cycle after CALC.
- start re-asserted every cycle during a fetch: ignored; exactly one done.
- reset asserted while in EDGE_RD:
  - Next cycle: all outputs zero, state IDLE.
  - A subsequent start on node 2 completes correctly.
- With EDGE_FETCH_BOUNDS_CHECK_EN, header 0x0041_0040 (count 65 > 64):
  - err=1, no edges, done pulse.
  - err clears on the next start.
